packet_arbiter: RTL
===================

Name: packet_arbiter

Overview:
- Round-robin arbiter that shares one downstream packet link between NUM_SRC packet-generator sources.
- Each source presents valid/ready beats carrying dest_addr, packet_type, payload and eop. The arbiter grants one source per packet and holds that grant until the eop beat is accepted.
- Sits between the packet generators and the router/sink. It also enforces a maximum packet length and reports violations.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- MAX_BEATS, 16, maximum beats per packet before forced release (2..255).
- SRC_W, $clog2(NUM_SRC), width of the source index.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  arbitration enable. When low, no new grant is issued; a packet in flight still completes.
- in_valid  in  NUM_SRC  per-source beat valid.
- in_ready  out  NUM_SRC  per-source beat accept.
- in_dest  in  2*NUM_SRC  per-source dest_addr; source i occupies bits [2i+1:2i].
- in_type  in  2*NUM_SRC  per-source packet_type (DATA/CONTROL/RESPONSE/RESERVED).
- in_payload  in  8*NUM_SRC  per-source payload.
- in_eop  in  NUM_SRC  per-source end-of-packet flag.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accept.
- out_dest  out  2  muxed dest_addr.
- out_type  out  2  muxed packet_type.
- out_payload  out  8  muxed payload.
- out_eop  out  1  muxed eop.
- grant_id  out  SRC_W  index of the current owner; valid while busy.
- busy  out  1  high in LOCKED.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset values:
  - state = IDLE, rr_ptr = 0, beat_cnt = 0, grant_id = 0.
  - busy = 0, timeout_err = 0, out_valid = 0, in_ready = 0.
  - out_dest, out_type, out_payload and out_eop are 0 while not busy.
- Handshake: a beat transfers in any cycle where out_valid && out_ready.
- States: IDLE and LOCKED.

IDLE:
- out_valid = 0 and in_ready = 0.
- If en = 1 and any in_valid is high, select the first requester searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., NUM_SRC-1, 0, ...).
- Register the selection into grant_id, go to LOCKED and clear beat_cnt.
- Arbitration latency is one cycle: a request first seen in cycle t can transfer its first beat in cycle t+1 at the earliest.

LOCKED (owner g = grant_id):
- out_valid = in_valid[g].
- out_* fields = source g fields.
- in_ready[g] = out_ready; in_ready of every other source = 0.
- The datapath is combinational within this state (no output register).
- On each transfer, beat_cnt increments by 1; its width is 8 bits and it saturates at MAX_BEATS.
- Transfer with out_eop = 1:
  - Go to IDLE and set rr_ptr = (g+1) mod NUM_SRC.
  - beat_cnt clears.
- Transfer without eop where beat_cnt+1 == MAX_BEATS:
  - Forced release: go to IDLE and set rr_ptr = (g+1) mod NUM_SRC.
  - timeout_err = 1 for the next cycle only.
  - The remaining beats of that source's packet compete as a new packet.
- eop and the limit on the same beat: eop wins and no timeout_err.
- en falling while LOCKED has no effect until release. After release the arbiter stays in IDLE while en = 0.
- A source that drops in_valid mid-packet keeps the lock; the arbiter waits indefinitely (no idle timeout).
- Reset asserted mid-packet: immediate return to reset values; the partial packet is lost downstream with no eop.
- NUM_SRC not a power of two: rr_ptr wraps at NUM_SRC, never at 2^SRC_W.

Decomposition:
- Shared package pkt_pkg:
  - packet_type_t enum (DATA = 0, CONTROL = 1, RESPONSE = 2, RESERVED = 3).
  - DEST_W = 2 and PAYLOAD_W = 8.
  - Arbiter state enum arb_state_t.
- One sub-module, rr_select: combinational round-robin pick. Inputs are req[NUM_SRC] and ptr; outputs are gnt_idx and gnt_any.
- The FSM, beat counter and datapath mux stay in packet_arbiter.

Test Plan:
1. Single source: src1 sends 3 beats (payload 0x11, 0x22, 0x33; eop on the last) with out_ready = 1.
   - Grant in the cycle after request; grant_id = 1 and out_payload follows in order.
   - busy drops the cycle after eop; rr_ptr = 2.
2. All 4 sources continuously request 2-beat packets.
   - Grant order is 0, 1, 2, 3, 0, ...
   - No interleaving of beats from different sources within a packet.
   - Idle cycles between packets: exactly 1.
3. Backpressure: out_ready toggles 1, 0, 0, 1 during a src2 packet.
   - in_ready[2] mirrors out_ready.
   - No beat is lost or duplicated, and the payload sequence at out is unchanged.
4. MAX_BEATS = 4: src0 sends 6 beats with no eop.
   - After the 4th transfer, release and timeout_err = 1 for one cycle.
   - src0 is re-granted only after the other requesters are served.
5. en = 0 asserted during a src3 packet.
   - The packet completes through eop, then no grant while en = 0.
   - en = 1 resumes, starting the search from src0.
6. reset pulse (high for 2 cycles) mid-packet.
   - All outputs return to reset values asynchronously.
   - rr_ptr = 0, so the first grant after reset goes to the lowest-indexed requester.

Source files
------------

// File: rtl/pkt_pkg.sv
// Shared packet-link types and widths for the arbiter and its round-robin picker.
package pkt_pkg;

    localparam int DEST_W    = 2;
    localparam int TYPE_W    = 2;
    localparam int PAYLOAD_W = 8;

    typedef enum logic [1:0] {
        DATA     = 2'd0,
        CONTROL  = 2'd1,
        RESPONSE = 2'd2,
        RESERVED = 2'd3
    } packet_type_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Modulo-n addition for operands already below n; keeps wrap at n, not 2^width.
    function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping at NUM_SRC.
module rr_select
    import pkt_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [SRC_W-1:0] cand_idx [NUM_SRC];
    logic             cand_req [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
            assign cand_idx[gi] = SRC_W'(wrap_add(32'(ptr), gi, NUM_SRC));
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester overwrites last.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one downstream link among NUM_SRC sources,
// with a per-packet beat limit that forces release and flags a one-cycle timeout.
module packet_arbiter
    import pkt_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int MAX_BEATS = 16,
    parameter int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [NUM_SRC-1:0]            in_valid,
    output logic [NUM_SRC-1:0]            in_ready,
    input  logic [DEST_W*NUM_SRC-1:0]     in_dest,
    input  logic [TYPE_W*NUM_SRC-1:0]     in_type,
    input  logic [PAYLOAD_W*NUM_SRC-1:0]  in_payload,
    input  logic [NUM_SRC-1:0]            in_eop,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DEST_W-1:0]             out_dest,
    output logic [TYPE_W-1:0]             out_type,
    output logic [PAYLOAD_W-1:0]          out_payload,
    output logic                          out_eop,
    output logic [SRC_W-1:0]              grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_BEATS);

    arb_state_t             state_reg;
    logic [SRC_W-1:0]       rr_ptr_reg;
    logic [SRC_W-1:0]       grant_id_reg;
    logic [7:0]             beat_cnt_reg;
    logic                   timeout_err_reg;

    logic [DEST_W-1:0]      dest_arr    [NUM_SRC];
    packet_type_t           type_arr    [NUM_SRC];
    logic [PAYLOAD_W-1:0]   payload_arr [NUM_SRC];

    logic                   gnt_any;
    logic [SRC_W-1:0]       gnt_idx;
    logic                   locked;
    logic                   xfer;
    logic [SRC_W-1:0]       next_ptr;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign dest_arr[gi]    = in_dest[gi*DEST_W +: DEST_W];
            assign type_arr[gi]    = packet_type_t'(in_type[gi*TYPE_W +: TYPE_W]);
            assign payload_arr[gi] = in_payload[gi*PAYLOAD_W +: PAYLOAD_W];
            assign in_ready[gi]    = locked && out_ready && (grant_id_reg == SRC_W'(gi));
        end
    endgenerate

    rr_select #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_rr_select (
        .req     (in_valid),
        .ptr     (rr_ptr_reg),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Owner's beat passes straight through; fields read as zero while no packet is owned.
    assign locked      = (state_reg == LOCKED);
    assign out_valid   = locked && in_valid[grant_id_reg];
    assign out_dest    = locked ? dest_arr[grant_id_reg] : '0;
    assign out_type    = locked ? TYPE_W'(type_arr[grant_id_reg]) : '0;
    assign out_payload = locked ? payload_arr[grant_id_reg] : '0;
    assign out_eop     = locked && in_eop[grant_id_reg];
    assign xfer        = out_valid && out_ready;
    assign next_ptr    = SRC_W'(wrap_add(32'(grant_id_reg), 1, NUM_SRC));

    assign busy        = locked;
    assign grant_id    = grant_id_reg;
    assign timeout_err = timeout_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            rr_ptr_reg      <= '0;
            grant_id_reg    <= '0;
            beat_cnt_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            timeout_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (en && gnt_any) begin
                        grant_id_reg <= gnt_idx;
                        beat_cnt_reg <= '0;
                        state_reg    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer) begin
                        if (out_eop) begin
                            state_reg    <= IDLE;
                            rr_ptr_reg   <= next_ptr;
                            beat_cnt_reg <= '0;
                        end else if (beat_cnt_reg + 8'd1 == MAX_CNT) begin
                            // Limit reached without eop: the rest of the packet re-arbitrates.
                            state_reg       <= IDLE;
                            rr_ptr_reg      <= next_ptr;
                            beat_cnt_reg    <= MAX_CNT;
                            timeout_err_reg <= 1'b1;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 8'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
